// File: rtl/product_accumulator.sv
// product_accumulator: sums a frame of 16-bit products into an ACC_W-bit result behind a valid/ready handshake
// Ports: clk, rst (sync, active high); prod_in/prod_valid/prod_last/prod_ready = term input;
//        acc_out/acc_count/acc_valid/acc_ready/acc_ovf = frame result output.
// Build option: define SATURATE_EN to clamp the sum at all-ones on overflow instead of wrapping.
module product_accumulator #(
   parameter int ACC_W     = 32,
   parameter int MAX_TERMS = 16,
   localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      prod_in,
   input  logic             prod_valid,
   input  logic             prod_last,
   output logic             prod_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] acc_count,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic             acc_ovf
);
`ifdef SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   sum;
   logic             accept, first;
   always_comb begin
      first  = state_q == IDLE;
      accept = prod_valid && state_q != DONE;
      // a new frame starts from zero so no stale sum or overflow leaks in
      sum    = {1'b0, first ? '0 : acc_q} + {{(ACC_W-15){1'b0}}, prod_in};
      cnt_nx = first ? CNT_W'(1) : cnt_q + 1'b1;
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (state_q == DONE) begin
         if (acc_ready) state_d = IDLE;
      end else if (accept) begin
         // a clamped sum plus any term re-carries, so saturation holds for later terms
         acc_d   = (SAT && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
         cnt_d   = cnt_nx;
         ovf_d   = (!first && ovf_q) || sum[ACC_W];
         state_d = (prod_last || cnt_nx == CNT_W'(MAX_TERMS)) ? DONE : ACCUM;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end
   assign prod_ready = state_q != DONE;
   assign acc_valid  = state_q == DONE;
   assign acc_out    = acc_q;
   assign acc_count  = cnt_q;
   assign acc_ovf    = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed self-checking bench for product_accumulator
module tb_product_accumulator;
   logic clk = 0, rst = 1;
   logic [15:0] pin = 0, pin32 = 0;
   logic pv = 0, pl = 0, ar = 0, pv32 = 0, pl32 = 0, ar32 = 0;
   logic pr, av, ao, pr32, av32, ao32;
   logic [19:0] aout, aout32;
   logic [2:0] acnt;
   logic [5:0] acnt32;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   product_accumulator #(.ACC_W(20), .MAX_TERMS(4)) u4 (
      .clk(clk), .rst(rst), .prod_in(pin), .prod_valid(pv), .prod_last(pl), .prod_ready(pr),
      .acc_out(aout), .acc_count(acnt), .acc_valid(av), .acc_ready(ar), .acc_ovf(ao));
   product_accumulator #(.ACC_W(20), .MAX_TERMS(32)) u32 (
      .clk(clk), .rst(rst), .prod_in(pin32), .prod_valid(pv32), .prod_last(pl32), .prod_ready(pr32),
      .acc_out(aout32), .acc_count(acnt32), .acc_valid(av32), .acc_ready(ar32), .acc_ovf(ao32));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [15:0] v, input logic l);
      pin = v; pv = 1; pl = l;
      for (int i = 0; i < 20 && !pr; i++) tick;
      tick;
      pv = 0; pl = 0;
   endtask
   task automatic consume;
      ar = 1;
      tick;
      ar = 0;
   endtask
   task automatic test_reset;
      rst = 1; tick; tick; rst = 0;
      checks++; if (aout !== 20'd0) begin errors++; $display("FAIL reset acc_out got %h want 0", aout); end
      checks++; if (acnt !== 3'd0) begin errors++; $display("FAIL reset acc_count got %0d want 0", acnt); end
      checks++; if (av !== 1'b0 || ao !== 1'b0) begin errors++; $display("FAIL reset valid/ovf got %b/%b want 0/0", av, ao); end
      checks++; if (pr !== 1'b1) begin errors++; $display("FAIL reset prod_ready got %b want 1", pr); end
   endtask
   task automatic test_basic;
      send(100, 0); send(200, 0); send(300, 1);
      checks++; if (av !== 1'b1) begin errors++; $display("FAIL basic acc_valid got %b want 1", av); end
      checks++; if (aout !== 20'd600) begin errors++; $display("FAIL basic acc_out got %0d want 600", aout); end
      checks++; if (acnt !== 3'd3) begin errors++; $display("FAIL basic acc_count got %0d want 3", acnt); end
      checks++; if (ao !== 1'b0 || pr !== 1'b0) begin errors++; $display("FAIL basic ovf/ready got %b/%b want 0/0", ao, pr); end
      consume;
      checks++; if (av !== 1'b0 || pr !== 1'b1) begin errors++; $display("FAIL basic release valid/ready got %b/%b want 0/1", av, pr); end
   endtask
   task automatic test_single;
      send(16'hABCD, 1);
      checks++; if (av !== 1'b1 || aout !== 20'h0ABCD || acnt !== 3'd1)
         begin errors++; $display("FAIL single got v=%b out=%h cnt=%0d want v=1 out=0abcd cnt=1", av, aout, acnt); end
      consume;
   endtask
   task automatic test_backpressure;
      send(10, 1);
      pin = 55; pv = 1; pl = 1;
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++; if (pr !== 1'b0 || av !== 1'b1 || aout !== 20'd10 || acnt !== 3'd1)
            begin errors++; $display("FAIL hold cycle %0d got ready=%b v=%b out=%0d cnt=%0d want 0/1/10/1", i, pr, av, aout, acnt); end
      end
      consume;
      checks++; if (av !== 1'b0 || pr !== 1'b1) begin errors++; $display("FAIL hold release valid/ready got %b/%b want 0/1", av, pr); end
      tick;
      pv = 0; pl = 0;
      checks++; if (av !== 1'b1 || aout !== 20'd55 || acnt !== 3'd1)
         begin errors++; $display("FAIL held term got v=%b out=%0d cnt=%0d want 1/55/1", av, aout, acnt); end
      consume;
   endtask
   task automatic test_autoclose;
      send(1000, 0); send(1000, 0); send(1000, 0);
      checks++; if (av !== 1'b0 || acnt !== 3'd3) begin errors++; $display("FAIL autoclose early got v=%b cnt=%0d want 0/3", av, acnt); end
      send(1000, 0);
      checks++; if (av !== 1'b1 || aout !== 20'd4000 || acnt !== 3'd4)
         begin errors++; $display("FAIL autoclose got v=%b out=%0d cnt=%0d want 1/4000/4", av, aout, acnt); end
      consume;
   endtask
   task automatic test_overflow;
      logic [19:0] exp;
`ifdef SATURATE_EN
      exp = 20'hFFFFF;
`else
      exp = 20'h0FFEF;
`endif
      pin32 = 16'hFFFF; pv32 = 1; pl32 = 0;
      for (int i = 0; i < 16; i++) tick;
      checks++; if (ao32 !== 1'b0 || aout32 !== 20'hFFFF0 || av32 !== 1'b0)
         begin errors++; $display("FAIL ovf pre got ovf=%b out=%h v=%b want 0/ffff0/0", ao32, aout32, av32); end
      pl32 = 1;
      tick;
      pv32 = 0; pl32 = 0;
      checks++; if (ao32 !== 1'b1 || av32 !== 1'b1) begin errors++; $display("FAIL ovf flag got ovf=%b v=%b want 1/1", ao32, av32); end
      checks++; if (aout32 !== exp || acnt32 !== 6'd17)
         begin errors++; $display("FAIL ovf sum got out=%h cnt=%0d want %h/17", aout32, acnt32, exp); end
      ar32 = 1; tick; ar32 = 0;
      pin32 = 3; pv32 = 1; pl32 = 1;
      tick;
      pv32 = 0; pl32 = 0;
      checks++; if (ao32 !== 1'b0 || aout32 !== 20'd3 || av32 !== 1'b1)
         begin errors++; $display("FAIL ovf clear got ovf=%b out=%0d v=%b want 0/3/1", ao32, aout32, av32); end
      ar32 = 1; tick; ar32 = 0;
   endtask
   task automatic test_midframe_reset;
      send(1, 0); send(2, 0);
      rst = 1; tick; rst = 0;
      checks++; if (aout !== 20'd0 || acnt !== 3'd0 || av !== 1'b0 || ao !== 1'b0 || pr !== 1'b1)
         begin errors++; $display("FAIL midreset got out=%0d cnt=%0d v=%b ovf=%b rdy=%b want 0/0/0/0/1", aout, acnt, av, ao, pr); end
      send(5, 0); send(7, 1);
      checks++; if (av !== 1'b1 || aout !== 20'd12 || acnt !== 3'd2)
         begin errors++; $display("FAIL post reset frame got v=%b out=%0d cnt=%0d want 1/12/2", av, aout, acnt); end
      consume;
   endtask
   initial begin
      test_reset;
      test_basic;
      test_single;
      test_backpressure;
      test_autoclose;
      test_overflow;
      test_midframe_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
